// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, oversampled by rx_clk_en, valid/ack handshake to the consumer.
// State | meaning: IDLE wait start edge | START verify mid start bit | DATA shift 8 bits | STOP check stop bit | WAIT_HIGH hold off until line idles
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_clk_en,
  input  logic       read_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_error,
  output logic       overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_next;
  logic            sync1, rx_s;
  logic [TW-1:0]   tick_cnt, tick_next;
  logic [2:0]      bit_idx, idx_next;
  logic [7:0]      sh, sh_next;
  logic            byte_done, stop_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_idx  <= idx_next;
      sh       <= sh_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    idx_next   = bit_idx;
    sh_next    = sh;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_clk_en && !rx_s) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (rx_clk_en) begin
          if (tick_cnt == HALF_M1) begin
            // A line that is high again at mid start bit was only a glitch.
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              tick_next  = '0;
              idx_next   = '0;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_clk_en) begin
          if (tick_cnt == FULL_M1) begin
            sh_next   = {rx_s, sh[7:1]};
            tick_next = '0;
            if (bit_idx == 3'd7) state_next = STOP;
            else                 idx_next   = bit_idx + 1'b1;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (rx_clk_en) begin
          if (tick_cnt == FULL_M1) begin
            tick_next = '0;
            if (rx_s) begin
              byte_done  = 1'b1;
              state_next = IDLE;
            end else begin
              stop_bad   = 1'b1;
              state_next = WAIT_HIGH;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // An ack coinciding with a new byte consumes the old one, so no overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_bad;
      if (byte_done) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
        overrun  <= !read_ack && (overrun || rx_valid);
      end else if (read_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE=16, one tick every 4 clk, so one bit = 64 clk.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_clk_en = 1'b0;
  logic       read_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_error, overrun;

  int n_cmp = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  logic [1:0] ph = 2'd0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_clk_en(rx_clk_en), .read_ack(read_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rx_clk_en = (ph == 2'd3);
    ph = ph + 2'd1;
  end

  always @(posedge clk) if (frame_error === 1'b1) ferr_cnt++;

  // Leaves us just after a negedge whose following posedge carries a tick.
  task automatic align();
    do begin @(negedge clk); #1; end while (ph != 2'd0);
  endtask

  // Start bit falls at c=0; stop sample lands on the posedge after c=612.
  task automatic send_bits(input logic [7:0] d, input logic stop, input int ncyc, input int ack_cycle);
    align();
    for (int c = 0; c < ncyc; c++) begin
      if (c < 64)       rx = 1'b0;
      else if (c < 576) rx = d[(c / 64) - 1];
      else              rx = stop;
      read_ack = (c == ack_cycle);
      @(negedge clk); #1;
    end
    read_ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); #1;
    read_ack = 1'b1;
    @(negedge clk); #1;
    read_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ferr=%b ovr=%b want 0 0", frame_error, overrun); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    send_bits(8'hA5, 1'b1, 640, -1);
    n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    n_cmp++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d pulses want 0", ferr_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b want 0", overrun); end
    do_ack();
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack: got valid %b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    bytes = '{8'h00, 8'hFF, 8'h80, 8'h01};
    for (int i = 0; i < 4; i++) begin
      send_bits(bytes[i], 1'b1, 640, -1);
      n_cmp++; if (rx_data !== bytes[i] || rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_byte%0d: got %h/%b want %h/1", i, rx_data, rx_valid, bytes[i]); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun%0d: got %b want 0", i, overrun); end
      do_ack();
      n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack%0d: got valid %b want 0", i, rx_valid); end
    end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cnt;
    align();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_in: got %b want 1", busy); end
    repeat (10) @(negedge clk);
    #1;
    rx = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    n_cmp++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d pulses want %0d", ferr_cnt, f0); end
  endtask

  task automatic test_frame_error();
    int f0;
    f0 = ferr_cnt;
    send_bits(8'h3C, 1'b0, 576 + 20 * 64, -1);
    n_cmp++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d clk high want 1", ferr_cnt - f0); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h01) begin n_fail++; $display("FAIL ferr_hold: got %h/%b want 01/0", rx_data, rx_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low: got %b want 1", busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release: got busy %b want 0", busy); end
    send_bits(8'h5A, 1'b1, 640, -1);
    n_cmp++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next: got %h/%b want 5a/1", rx_data, rx_valid); end
    n_cmp++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_extra: got %0d pulses want 1", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    send_bits(8'hC3, 1'b1, 350, -1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: got %h/%b want 00/0", rx_data, rx_valid); end
    n_cmp++; if (busy !== 1'b0 || overrun !== 1'b0 || frame_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got busy=%b ovr=%b ferr=%b want 0 0 0", busy, overrun, frame_error); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    send_bits(8'h69, 1'b1, 640, -1);
    n_cmp++; if (rx_data !== 8'h69 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next: got %h/%b want 69/1", rx_data, rx_valid); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_bits(8'h11, 1'b1, 640, -1);
    n_cmp++; if (rx_data !== 8'h11 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %h ovr=%b want 11 0", rx_data, overrun); end
    send_bits(8'h22, 1'b1, 640, -1);
    n_cmp++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_second: got %h/%b want 22/1", rx_data, rx_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    do_ack();
    n_cmp++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got valid=%b ovr=%b want 0 0", rx_valid, overrun); end
    send_bits(8'h11, 1'b1, 640, -1);
    send_bits(8'h22, 1'b1, 640, 612);
    n_cmp++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL simul_data: got %h/%b want 22/1", rx_data, rx_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL simul_overrun: got %b want 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
